// File: rtl/m_unit_arbiter_if.sv
// Bundle of the two PCPI-style requester ports and the shared M-unit port.
// The arbiter connects through the slave modport; the requesters and the
// M unit together (a testbench, or the surrounding core) use the master modport.
interface m_unit_arbiter_if;
  // Requester 0 / 1
  logic        valid0;
  logic        valid1;
  logic [31:0] instruction0;
  logic [31:0] instruction1;
  logic [31:0] rs1_0;
  logic [31:0] rs1_1;
  logic [31:0] rs2_0;
  logic [31:0] rs2_1;
  logic        wr0;
  logic        wr1;
  logic [31:0] rd0;
  logic [31:0] rd1;
  logic        busy0;
  logic        busy1;
  logic        ready0;
  logic        ready1;
  // Shared M unit
  logic        m_valid;
  logic [31:0] m_instruction;
  logic [31:0] m_rs1;
  logic [31:0] m_rs2;
  logic        m_wr;
  logic [31:0] m_rd;
  logic        m_busy;
  logic        m_ready;
  logic        timeout;

  modport slave (
    input  valid0, valid1, instruction0, instruction1,
    input  rs1_0, rs1_1, rs2_0, rs2_1,
    output wr0, wr1, rd0, rd1, busy0, busy1, ready0, ready1,
    output m_valid, m_instruction, m_rs1, m_rs2,
    input  m_wr, m_rd, m_busy, m_ready,
    output timeout
  );

  modport master (
    output valid0, valid1, instruction0, instruction1,
    output rs1_0, rs1_1, rs2_0, rs2_1,
    input  wr0, wr1, rd0, rd1, busy0, busy1, ready0, ready1,
    input  m_valid, m_instruction, m_rs1, m_rs2,
    output m_wr, m_rd, m_busy, m_ready,
    input  timeout
  );
endinterface

// File: rtl/m_unit_arbiter.sv
// m_unit_arbiter: shares one RISC-V M-extension multiply/divide unit between
// two PCPI-style requesters. Round-robin grant, latched operands, one-cycle
// RESP state that returns the result to the winner.
// Optional feature: define M_ARB_TIMEOUT_EN to enable the ISSUE watchdog that
// aborts after TIMEOUT_CYCLES cycles without m_ready and pulses timeout.
module m_unit_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CW             = 7
) (
  input logic          clk,
  input logic          reset,
  m_unit_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state;
  logic        rr_ptr;
  logic        gnt;
  logic        mask_vld;
  logic        mask_id;

  logic        m_valid_r;
  logic [31:0] m_instr_r;
  logic [31:0] m_rs1_r;
  logic [31:0] m_rs2_r;
  logic        ready0_r;
  logic        ready1_r;
  logic        wr0_r;
  logic        wr1_r;
  logic [31:0] rd0_r;
  logic [31:0] rd1_r;
  logic        busy0_r;
  logic        busy1_r;

  logic        is_m0;
  logic        is_m1;
  logic        cand0;
  logic        cand1;
  logic        grant_sel;

`ifdef M_ARB_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] tmo_cnt;
  logic          timeout_r;
`else
  logic [CW-1:0] unused_tmo_limit;
  assign unused_tmo_limit = CW'(TIMEOUT_CYCLES);
`endif

  // m_busy is informational only; the handshake is driven by m_ready.
  logic unused_m_busy;
  assign unused_m_busy = bus.m_busy;

  // Decode M-extension requests and pick the winner among unmasked candidates.
  always_comb begin
    is_m0     = bus.valid0 & (bus.instruction0[6:0] == 7'b0110011) &
                (bus.instruction0[31:25] == 7'b0000001);
    is_m1     = bus.valid1 & (bus.instruction1[6:0] == 7'b0110011) &
                (bus.instruction1[31:25] == 7'b0000001);
    cand0     = is_m0 & ~(mask_vld & ~mask_id);
    cand1     = is_m1 & ~(mask_vld &  mask_id);
    grant_sel = (cand0 & cand1) ? rr_ptr : cand1;
  end

  // Arbitration FSM: grant in IDLE, hold request in ISSUE, answer in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      gnt       <= 1'b0;
      mask_vld  <= 1'b0;
      mask_id   <= 1'b0;
      m_valid_r <= 1'b0;
      m_instr_r <= '0;
      m_rs1_r   <= '0;
      m_rs2_r   <= '0;
      ready0_r  <= 1'b0;
      ready1_r  <= 1'b0;
      wr0_r     <= 1'b0;
      wr1_r     <= 1'b0;
      rd0_r     <= '0;
      rd1_r     <= '0;
`ifdef M_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
      timeout_r <= 1'b0;
`endif
    end else begin
      // Response outputs are single-cycle; they are zero unless set below.
      ready0_r <= 1'b0;
      ready1_r <= 1'b0;
      wr0_r    <= 1'b0;
      wr1_r    <= 1'b0;
      rd0_r    <= '0;
      rd1_r    <= '0;
`ifdef M_ARB_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // The mask only protects the first IDLE cycle after a response.
          mask_vld <= 1'b0;
          if (cand0 | cand1) begin
            m_instr_r <= grant_sel ? bus.instruction1 : bus.instruction0;
            m_rs1_r   <= grant_sel ? bus.rs1_1 : bus.rs1_0;
            m_rs2_r   <= grant_sel ? bus.rs2_1 : bus.rs2_0;
            gnt       <= grant_sel;
            rr_ptr    <= ~grant_sel;
            m_valid_r <= 1'b1;
            state     <= ISSUE;
`ifdef M_ARB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end
        ISSUE: begin
          if (bus.m_ready) begin
            m_valid_r <= 1'b0;
            state     <= RESP;
            if (gnt) begin
              ready1_r <= 1'b1;
              wr1_r    <= bus.m_wr;
              rd1_r    <= bus.m_rd;
            end else begin
              ready0_r <= 1'b1;
              wr0_r    <= bus.m_wr;
              rd0_r    <= bus.m_rd;
            end
          end
`ifdef M_ARB_TIMEOUT_EN
          // Watchdog abort: the requester still gets ready, with zero result.
          else if (tmo_cnt == TMO_LIMIT) begin
            m_valid_r <= 1'b0;
            state     <= RESP;
            timeout_r <= 1'b1;
            if (gnt) ready1_r <= 1'b1;
            else     ready0_r <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          // Keep the just-served requester out of the next grant decision.
          mask_vld <= 1'b1;
          mask_id  <= gnt;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Busy tracking: set once an M request is seen, cleared after its ready;
  // a requester that withdraws before being granted drops busy as well.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy0_r <= 1'b0;
      busy1_r <= 1'b0;
    end else begin
      if (ready0_r)                          busy0_r <= 1'b0;
      else if (is_m0)                        busy0_r <= 1'b1;
      else if (!((state != IDLE) && !gnt))   busy0_r <= 1'b0;

      if (ready1_r)                          busy1_r <= 1'b0;
      else if (is_m1)                        busy1_r <= 1'b1;
      else if (!((state != IDLE) && gnt))    busy1_r <= 1'b0;
    end
  end

  assign bus.m_valid       = m_valid_r;
  assign bus.m_instruction = m_instr_r;
  assign bus.m_rs1         = m_rs1_r;
  assign bus.m_rs2         = m_rs2_r;
  assign bus.ready0        = ready0_r;
  assign bus.ready1        = ready1_r;
  assign bus.wr0           = wr0_r;
  assign bus.wr1           = wr1_r;
  assign bus.rd0           = rd0_r;
  assign bus.rd1           = rd1_r;
  assign bus.busy0         = busy0_r;
  assign bus.busy1         = busy1_r;
`ifdef M_ARB_TIMEOUT_EN
  assign bus.timeout       = timeout_r;
`else
  assign bus.timeout       = 1'b0;
`endif

endmodule
